fp_add_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision add/subtract unit with valid/ready handshakes on both sides. It accepts an operand pair from an upstream initiator (file-driven bench or datapath sequencer) and returns one result per accepted request. It is the clocked, handshaked counterpart to the combinational adder, and drops into the same FP ALU. It uses the same operand/result naming and the same under_overflow flag semantics.

---
 rtl/fp_add_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-754 single add/sub with valid/ready.
// Fixed six-state pipeline per request; flush-to-zero, RNE rounding.
module fp_add_seq #(
   parameter bit LATENCY_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] para1,
   input  logic [31:0] para2,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        under_overflow
);

   typedef enum logic [2:0] {
      IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
   } state_t;

   state_t state;

   logic [31:0] a_q, b_q;
   logic        sub_q;

   logic        u_sa, u_sb;
   logic [7:0]  u_ea, u_eb;
   logic [23:0] u_ma, u_mb;
   logic        nan_a, nan_b, inf_a, inf_b;
   logic        u_spec;
   logic [31:0] u_res;

   logic        sa_q, sb_q, spec_q, zsign_q;
   logic [7:0]  ea_q, eb_q;
   logic [23:0] ma_q, mb_q;
   logic [31:0] spec_res_q;

   logic        a_big;
   logic        al_s;
   logic [7:0]  al_be, al_se, diff;
   logic [23:0] al_bm, al_sm;
   logic [26:0] fld, al_m;

   logic        big_s_q, eff_sub_q;
   logic [7:0]  big_e_q;
   logic [26:0] big_m_q, sml_m_q;

   logic [27:0]       sum_q;
   logic signed [9:0] exp_q;
   logic              sign_q;

   logic [4:0]        lz;
   logic [26:0]       n_m;
   logic signed [9:0] n_e;

   logic [26:0]       nm_q;
   logic signed [9:0] ne_q;
   logic              nzero_q;

   logic              up;
   logic [24:0]       rm;
   logic signed [9:0] r_e;
   logic [22:0]       r_f;
   logic [31:0]       r_out;
   logic              r_uf;

   // Field extraction, hidden bit, NaN/Inf detection and special result.
   always_comb begin
      u_sa   = a_q[31];
      u_sb   = b_q[31] ^ sub_q;
      u_ea   = a_q[30:23];
      u_eb   = b_q[30:23];
      u_ma   = (u_ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
      u_mb   = (u_eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
      nan_a  = (&u_ea) & (|a_q[22:0]);
      nan_b  = (&u_eb) & (|b_q[22:0]);
      inf_a  = (&u_ea) & ~(|a_q[22:0]);
      inf_b  = (&u_eb) & ~(|b_q[22:0]);
      u_spec = nan_a | nan_b | inf_a | inf_b;
      u_res  = 32'h7FC0_0000;
      if (!(nan_a | nan_b) && !(inf_a & inf_b & (u_sa ^ u_sb))) begin
         if (inf_a) u_res = {u_sa, 8'hFF, 23'd0};
         else       u_res = {u_sb, 8'hFF, 23'd0};
      end
   end

   // Order by magnitude and shift the smaller significand with sticky.
   always_comb begin
      a_big = {ea_q, ma_q} >= {eb_q, mb_q};
      al_s  = a_big ? sa_q : sb_q;
      al_be = a_big ? ea_q : eb_q;
      al_se = a_big ? eb_q : ea_q;
      al_bm = a_big ? ma_q : mb_q;
      al_sm = a_big ? mb_q : ma_q;
      diff  = al_be - al_se;
      fld   = {al_sm, 3'b000};
      if (diff >= 8'd27) begin
         al_m = {26'd0, |al_sm};
      end else begin
         al_m    = fld >> diff;
         al_m[0] = al_m[0] | (|(fld & ~(27'h7FF_FFFF << diff)));
      end
   end

   // Leading-one position of the 27-bit sum field.
   always_comb begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (sum_q[i]) lz = 5'(26 - i);
      end
   end

   // Normalise: one right shift on carry, else left shift to bit 26.
   always_comb begin
      if (sum_q[27]) begin
         n_m = sum_q[27:1] | {26'd0, sum_q[0]};
         n_e = exp_q + 10'sd1;
      end else begin
         n_m = sum_q[26:0] << lz;
         n_e = exp_q - $signed({5'd0, lz});
      end
   end

   // Round to nearest even, then apply overflow/underflow/special rules.
   always_comb begin
      up = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
      rm = {1'b0, nm_q[26:3]} + {24'd0, up};
      if (rm[24]) begin
         r_e = ne_q + 10'sd1;
         r_f = rm[23:1];
      end else begin
         r_e = ne_q;
         r_f = rm[22:0];
      end
      r_uf = 1'b0;
      if (spec_q) begin
         r_out = spec_res_q;
      end else if (nzero_q) begin
         r_out = {zsign_q, 31'd0};
      end else if (r_e >= 10'sd255) begin
         r_out = {sign_q, 8'hFF, 23'd0};
         r_uf  = 1'b1;
      end else if (r_e <= 10'sd0) begin
         r_out = {sign_q, 31'd0};
         r_uf  = 1'b1;
      end else begin
         r_out = {sign_q, r_e[7:0], r_f};
      end
   end

   // Datapath registers, each loaded in the state that produces them.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_q   <= para1;
               b_q   <= para2;
               sub_q <= sub;
            end
         end
         UNPACK: begin
            sa_q       <= u_sa;
            sb_q       <= u_sb;
            ea_q       <= u_ea;
            eb_q       <= u_eb;
            ma_q       <= u_ma;
            mb_q       <= u_mb;
            spec_q     <= u_spec;
            spec_res_q <= u_res;
            zsign_q    <= u_sa & u_sb;
         end
         ALIGN: begin
            big_s_q   <= al_s;
            big_e_q   <= al_be;
            big_m_q   <= {al_bm, 3'b000};
            sml_m_q   <= al_m;
            eff_sub_q <= sa_q ^ sb_q;
         end
         ADD: begin
            sum_q  <= eff_sub_q ? ({1'b0, big_m_q} - {1'b0, sml_m_q})
                                : ({1'b0, big_m_q} + {1'b0, sml_m_q});
            exp_q  <= $signed({2'b00, big_e_q});
            sign_q <= big_s_q;
         end
         NORM: begin
            nm_q    <= n_m;
            ne_q    <= n_e;
            nzero_q <= (sum_q == 28'd0);
         end
         default: ;
      endcase
   end

   // Control FSM with registered handshake outputs and result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         out            <= 32'h0;
         under_overflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= UNPACK;
                  in_ready <= 1'b0;
               end
            end
            UNPACK: state <= ALIGN;
            ALIGN:  state <= ADD;
            ADD:    state <= NORM;
            NORM:   state <= ROUND;
            ROUND: begin
               state          <= DONE;
               out_valid      <= 1'b1;
               out            <= r_out;
               under_overflow <= r_uf;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   generate
      if (LATENCY_CHECK) begin : g_lat
         logic [2:0] lat_cnt;

         // Cycles since the last accept, saturating.
         always_ff @(posedge clk) begin
            if (rst)
               lat_cnt <= 3'd0;
            else if (in_valid && in_ready)
               lat_cnt <= 3'd1;
            else if (lat_cnt != 3'd0 && lat_cnt != 3'd7)
               lat_cnt <= lat_cnt + 3'd1;
         end

         // The result must be registered exactly five edges after accept.
         always_ff @(posedge clk) begin
            if (!rst && state == ROUND)
               assert (lat_cnt == 3'd5)
               else $error("fp_add_seq latency deviation %0d", lat_cnt);
         end
      end
   endgenerate

endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed and random checks of fp_add_seq
// against a real-arithmetic reference model.
module tb_fp_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] para1;
   logic [31:0] para2;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        under_overflow;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fp_add_seq #(.LATENCY_CHECK(1'b1)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .para1          (para1),
      .para2          (para2),
      .sub            (sub),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out            (out),
      .under_overflow (under_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic real mag(input logic [31:0] x);
      if (x[30:23] == 8'd0) return 0.0;
      return (1.0 + real'(x[22:0]) / 8388608.0)
             * (2.0 ** real'(int'(x[30:23]) - 127));
   endfunction

   // Exact real sum rounded to single precision by nearest-even.
   function automatic void ref_add(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic s,
                                   output logic [31:0] r,
                                   output logic u);
      logic        sa, sb, na, nb, ia, ib, sg;
      real         va, vb, sm;
      logic [63:0] bits;
      logic [52:0] m53;
      logic [24:0] q;
      logic [28:0] rem;
      int          e, be;
      sa = a[31];
      sb = b[31] ^ s;
      na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      u  = 1'b0;
      r  = 32'h0;
      if (na || nb || (ia && ib && sa != sb)) begin
         r = 32'h7FC0_0000;
      end else if (ia) begin
         r = {sa, 8'hFF, 23'd0};
      end else if (ib) begin
         r = {sb, 8'hFF, 23'd0};
      end else begin
         va = sa ? -mag(a) : mag(a);
         vb = sb ? -mag(b) : mag(b);
         sm = va + vb;
         if (sm == 0.0) begin
            r = {sa & sb, 31'd0};
         end else begin
            sg = (sm < 0.0);
            if (sg) sm = -sm;
            bits = $realtobits(sm);
            e    = int'(bits[62:52]) - 1023;
            m53  = {1'b1, bits[51:0]};
            q    = {1'b0, m53[52:29]};
            rem  = m53[28:0];
            if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && q[0]))
               q = q + 25'd1;
            if (q[24]) begin
               q = q >> 1;
               e++;
            end
            be = e + 127;
            if (be >= 255) begin
               r = {sg, 8'hFF, 23'd0};
               u = 1'b1;
            end else if (be <= 0) begin
               r = {sg, 31'd0};
               u = 1'b1;
            end else begin
               r = {sg, 8'(be), q[22:0]};
            end
         end
      end
   endfunction

   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, output logic [31:0] r,
                        output logic u, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      para1    = a;
      para2    = b;
      sub      = s;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      r = out;
      u = under_overflow;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic s,
                      input logic [31:0] er, input logic eu);
      logic [31:0] r;
      logic        u;
      int          lat;
      do_op(a, b, s, r, u, lat);
      check({tag, "_out"}, r, er);
      check({tag, "_uf"}, {31'd0, u}, {31'd0, eu});
      check({tag, "_lat"}, lat, 32'd5);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b, r, er, hold;
      logic        s, u, eu, seen;
      int          lat, ea, eb, mode, w;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sub       = 1'b0;
      para1     = 32'h0;
      para2     = 32'h0;
      tick();
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out", out, 32'h0);
      check("rst_uf", {31'd0, under_overflow}, 32'd0);

      run("basic",    32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0);
      run("subzero",  32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0);
      run("tie_even", 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0);
      run("tie_up",   32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 1'b0);
      run("ovf",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1);
      run("unf",      32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b1);
      run("subnorm",  32'h0080_0000, 32'h0040_0000, 1'b0, 32'h0080_0000, 1'b0);
      run("inf_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0);
      run("nan",      32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0);
      run("ninf",     32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 1'b0);
      run("pinf2",    32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0);
      run("nz_nz",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);
      run("nz_mpz",   32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0);
      run("pz_nz",    32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0);

      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      para1    = 32'h4040_0000;
      para2    = 32'h3F80_0000;
      sub      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_lat", lat, 32'd5);
      hold = out;
      check("bp_out", hold, 32'h4080_0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_out", out, 32'h4080_0000);
         check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_ret_valid", {31'd0, out_valid}, 32'd0);
      check("bp_ret_ready", {31'd0, in_ready}, 32'd1);

      para1    = 32'h3F80_0000;
      para2    = 32'h4000_0000;
      sub      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("mrst_no_pulse", {31'd0, seen}, 32'd0);
      run("after_rst", 32'h4040_0000, 32'hBF80_0000, 1'b0,
          32'h4000_0000, 1'b0);

      for (int n = 0; n < 150; n++) begin
         ea   = int'($urandom_range(1, 254));
         a    = {1'($urandom), 8'(ea), 23'($urandom)};
         mode = int'($urandom_range(0, 7));
         case (mode)
            0: b = {1'($urandom), a[30:0]};
            1: b = {1'($urandom), 8'd0, 23'($urandom)};
            2: begin
               a[30:23] = 8'(253 + $urandom_range(0, 1));
               b = {1'($urandom), 8'(253 + $urandom_range(0, 1)),
                    23'($urandom)};
            end
            3: begin
               a[30:23] = 8'($urandom_range(1, 3));
               b = {1'($urandom), 8'($urandom_range(1, 3)), 23'($urandom)};
            end
            4: b = {1'($urandom), 8'hFF,
                    ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom)};
            default: begin
               eb = ea + int'($urandom_range(0, 60)) - 30;
               if (eb < 1) eb = 1;
               if (eb > 254) eb = 254;
               b = {1'($urandom), 8'(eb), 23'($urandom)};
            end
         endcase
         if ($urandom_range(0, 1) != 0) begin
            r = a;
            a = b;
            b = r;
         end
         s = 1'($urandom);
         ref_add(a, b, s, er, eu);
         do_op(a, b, s, r, u, lat);
         check($sformatf("rnd%0d_out %h%s%h", n, a, s ? "-" : "+", b),
               r, er);
         check($sformatf("rnd%0d_uf", n), {31'd0, u}, {31'd0, eu});
         check($sformatf("rnd%0d_lat", n), lat, 32'd5);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
